// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked bits, ACK.
// Optional watchdog on the device-clocked phases: define PS2_TX_WATCHDOG_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] InhLast = IW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  state_e        r_state, w_state_nxt;
  logic [8:0]    r_shift, w_shift_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [IW-1:0] r_inh, w_inh_nxt;
  logic          r_ok, w_ok_nxt;
  logic          r_clk_drv, w_clk_drv_nxt;
  logic          r_dat_drv, w_dat_drv_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

  // Synchronizers reset to the idle (high) line level so reset cannot fake a fall.
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  assign w_fall = r_clk_s3 & ~r_clk_s2;

`ifdef PS2_TX_WATCHDOG_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WdtLast = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_wdt, w_wdt_nxt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2Clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= PS2Data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit     <= '0;
      r_inh     <= '0;
      r_ok      <= 1'b0;
      r_clk_drv <= 1'b0;
      r_dat_drv <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit     <= w_bit_nxt;
      r_inh     <= w_inh_nxt;
      r_ok      <= w_ok_nxt;
      r_clk_drv <= w_clk_drv_nxt;
      r_dat_drv <= w_dat_drv_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

`ifdef PS2_TX_WATCHDOG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= w_wdt_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_nxt     = r_bit;
    w_inh_nxt     = r_inh;
    w_ok_nxt      = r_ok;
    w_clk_drv_nxt = r_clk_drv;
    w_dat_drv_nxt = r_dat_drv;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      StIdle: begin
        w_clk_drv_nxt = 1'b0;
        w_dat_drv_nxt = 1'b0;
        if (tx_valid) begin
          w_shift_nxt   = {~^tx_data, tx_data};
          w_inh_nxt     = '0;
          w_bit_nxt     = '0;
          w_clk_drv_nxt = 1'b1;
          w_state_nxt   = StInhibit;
        end
      end
      StInhibit: begin
        if (r_inh == InhLast) begin
          w_dat_drv_nxt = 1'b1;
          w_state_nxt   = StReq;
        end else begin
          w_inh_nxt = r_inh + 1'b1;
        end
      end
      StReq: begin
        // Data stays low as the start bit once the clock is released.
        w_clk_drv_nxt = 1'b0;
        w_bit_nxt     = '0;
        w_state_nxt   = StSend;
      end
      StSend: begin
        if (w_fall) begin
          if (r_bit == 4'd9) begin
            w_dat_drv_nxt = 1'b0;
            w_bit_nxt     = 4'd10;
            w_state_nxt   = StAck;
          end else begin
            w_dat_drv_nxt = ~r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[8:1]};
            w_bit_nxt     = r_bit + 4'd1;
          end
        end
      end
      StAck: begin
        if (w_fall) begin
          w_ok_nxt    = ~r_dat_s2;
          w_state_nxt = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (r_clk_s2 && r_dat_s2) begin
          w_done_nxt  = r_ok;
          w_err_nxt   = ~r_ok;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_clk_drv_nxt = 1'b0;
        w_dat_drv_nxt = 1'b0;
        w_state_nxt   = StIdle;
      end
    endcase

`ifdef PS2_TX_WATCHDOG_EN
    w_wdt_nxt = r_wdt;
    if (r_state == StReq) begin
      w_wdt_nxt = '0;
    end else if (r_state == StSend || r_state == StAck || r_state == StWaitIdle) begin
      if (r_wdt == WdtLast) begin
        w_clk_drv_nxt = 1'b0;
        w_dat_drv_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b1;
        w_state_nxt   = StIdle;
      end else begin
        w_wdt_nxt = r_wdt + 1'b1;
      end
    end
`endif
  end

  assign tx_ready           = (r_state == StIdle);
  // Busy stays high through the completion pulse cycle.
  assign tx_busy            = (r_state != StIdle) | r_done | r_err;
  assign tx_done            = r_done;
  assign tx_error           = r_err;
  assign ps2_clk_drive_low  = r_clk_drv;
  assign ps2_data_drive_low = r_dat_drv;

endmodule
